// File: rtl/timing_engine_pkg.sv
// Shared types and constants for the radio timing-engine sequencer.
package timing_engine_pkg;

  localparam int TE_CNT_W_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_ENABLE = 2'd2;
  localparam logic [1:0] ST_RX     = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    ENABLE = ST_ENABLE,
    RX     = ST_RX
  } te_state_e;

endpackage

// File: rtl/te_channel_fsm.sv
// One timing-engine channel: sequencing FSM, delay counter, sticky lock-loss
// flag and isolation clamp on the decoded outputs.
module te_channel_fsm
  import timing_engine_pkg::*;
#(
  parameter int CNT_W = TE_CNT_W_DEFAULT
) (
  input  logic             ck,
  input  logic             arst,
  input  logic             pll_settled,
  input  logic             t_arst_fs,
  input  logic             isolate,
  input  logic [CNT_W-1:0] settle_dly,
  input  logic [CNT_W-1:0] ramp_dly,
  input  logic             err_clr,
  output logic             radio_enable,
  output logic             radio_rx_en,
  output logic             busy,
  output logic             lock_err
);

  te_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_err_q, lock_err_d;
  logic             set_err;

  // Next-state, counter and lock-error logic; aborts outrank progression.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lock_err_d = lock_err_q;
    set_err    = 1'b0;
    if (isolate) begin
      state_d = IDLE;
    end else if (t_arst_fs) begin
      state_d = IDLE;
    end else if (!pll_settled) begin
      state_d = IDLE;
      // Only a lock drop seen while receiving is reported as an error.
      set_err = (state_q == RX);
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SETTLE;
          cnt_d   = settle_dly;
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d = ENABLE;
            cnt_d   = ramp_dly;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ENABLE: begin
          if (cnt_q == '0) begin
            state_d = RX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        RX: begin
          state_d = RX;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    // A new error in the same cycle as a clear must survive.
    if (set_err) begin
      lock_err_d = 1'b1;
    end else if (err_clr) begin
      lock_err_d = 1'b0;
    end
  end

  // State, counter and sticky flag registers with asynchronous reset.
  always_ff @(posedge ck or negedge arst) begin
    if (!arst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lock_err_q <= lock_err_d;
    end
  end

  // Moore decode; isolate forces the radio-facing outputs low immediately.
  assign radio_enable = ((state_q == ENABLE) || (state_q == RX)) & ~isolate;
  assign radio_rx_en  = (state_q == RX) & ~isolate;
  assign busy         = (state_q != IDLE) & ~isolate;
  assign lock_err     = lock_err_q;

endmodule

// File: rtl/timing_engine_seq.sv
// Multi-channel radio timing-engine sequencer: independent channel FSMs
// sharing the settle and ramp delay configuration.
module timing_engine_seq
  import timing_engine_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = TE_CNT_W_DEFAULT
) (
  input  logic                ck,
  input  logic                arst,
  input  logic [CHANNELS-1:0] pllSettled,
  input  logic [CHANNELS-1:0] tArstFs,
  input  logic [CHANNELS-1:0] isolate,
  input  logic [CNT_W-1:0]    settleDly,
  input  logic [CNT_W-1:0]    rampDly,
  input  logic [CHANNELS-1:0] errClr,
  output logic [CHANNELS-1:0] radioEnable,
  output logic [CHANNELS-1:0] radioRxEn,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] lockErr
);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    te_channel_fsm #(
      .CNT_W(CNT_W)
    ) u_fsm (
      .ck          (ck),
      .arst        (arst),
      .pll_settled (pllSettled[ch]),
      .t_arst_fs   (tArstFs[ch]),
      .isolate     (isolate[ch]),
      .settle_dly  (settleDly),
      .ramp_dly    (rampDly),
      .err_clr     (errClr[ch]),
      .radio_enable(radioEnable[ch]),
      .radio_rx_en (radioRxEn[ch]),
      .busy        (busy[ch]),
      .lock_err    (lockErr[ch])
    );
  end

endmodule
